// File: rtl/l2_request_arbiter.sv
// l2_request_arbiter: round-robin arbiter placing the icache and dcache L2
// request channels onto the single L2 request channel. A grant is held for a
// client's whole multi-beat operation, i.e. until that client drops valid.
// Optional feature macro: L2_ARB_PERF_COUNTERS_EN adds per-client grant counters.

package l2_arb_pkg;
  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } memory_operation_e;
endpackage

module l2_request_arbiter
  import l2_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // icache client
  input  logic                  ic_req_valid,
  input  memory_operation_e     ic_req_type,
  input  logic [ADDR_WIDTH-1:0] ic_req_address,
  output logic                  ic_req_fulfilled,
  output logic [DATA_WIDTH-1:0] ic_rdata,
  // dcache client
  input  logic                  dc_req_valid,
  input  memory_operation_e     dc_req_type,
  input  logic [ADDR_WIDTH-1:0] dc_req_address,
  input  logic [DATA_WIDTH-1:0] dc_req_wdata,
  output logic                  dc_req_fulfilled,
  output logic [DATA_WIDTH-1:0] dc_rdata,
  // L2 channel
  output logic                  l2_req_valid,
  output memory_operation_e     l2_req_type,
  output logic [ADDR_WIDTH-1:0] l2_req_address,
  output logic [DATA_WIDTH-1:0] l2_req_wdata,
  input  logic                  l2_req_fulfilled,
  input  logic [DATA_WIDTH-1:0] l2_rdata
`ifdef L2_ARB_PERF_COUNTERS_EN
  ,
  output logic [31:0]           ic_grant_count,
  output logic [31:0]           dc_grant_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_GRANT_IC = 2'b01,
    ST_GRANT_DC = 2'b10
  } state_e;

  typedef enum logic {
    LG_IC = 1'b0,
    LG_DC = 1'b1
  } last_grant_e;

  state_e      state;
  state_e      next_state;
  last_grant_e last_grant;
  logic        take_ic;
  logic        take_dc;

  // Next-state selection: round-robin tie break from idle, hold while owner valid
  always_comb begin
    next_state = state;
    take_ic    = 1'b0;
    take_dc    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ic_req_valid && dc_req_valid) begin
          if (last_grant == LG_DC) begin
            next_state = ST_GRANT_IC;
            take_ic    = 1'b1;
          end else begin
            next_state = ST_GRANT_DC;
            take_dc    = 1'b1;
          end
        end else if (ic_req_valid) begin
          next_state = ST_GRANT_IC;
          take_ic    = 1'b1;
        end else if (dc_req_valid) begin
          next_state = ST_GRANT_DC;
          take_dc    = 1'b1;
        end
      end
      ST_GRANT_IC: if (!ic_req_valid) next_state = ST_IDLE;
      ST_GRANT_DC: if (!dc_req_valid) next_state = ST_IDLE;
      default: begin
        next_state = state_e'('x);
        take_ic    = 1'bx;
        take_dc    = 1'bx;
      end
    endcase
  end

  // State and round-robin history registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      last_grant <= LG_DC;
    end else begin
      state <= next_state;
      if (take_ic) begin
        last_grant <= LG_IC;
      end else if (take_dc) begin
        last_grant <= LG_DC;
      end
    end
  end

  // Output steering: combinational pass-through of the granted client
  always_comb begin
    ic_rdata = l2_rdata;
    dc_rdata = l2_rdata;
    case (state)
      ST_IDLE: begin
        l2_req_valid     = 1'b0;
        l2_req_type      = LOAD;
        l2_req_address   = '0;
        l2_req_wdata     = '0;
        ic_req_fulfilled = 1'b0;
        dc_req_fulfilled = 1'b0;
      end
      ST_GRANT_IC: begin
        l2_req_valid     = ic_req_valid;
        l2_req_type      = ic_req_type;
        l2_req_address   = ic_req_address;
        l2_req_wdata     = '0;
        ic_req_fulfilled = l2_req_fulfilled;
        dc_req_fulfilled = 1'b0;
      end
      ST_GRANT_DC: begin
        l2_req_valid     = dc_req_valid;
        l2_req_type      = dc_req_type;
        l2_req_address   = dc_req_address;
        l2_req_wdata     = dc_req_wdata;
        ic_req_fulfilled = 1'b0;
        dc_req_fulfilled = l2_req_fulfilled;
      end
      default: begin
        l2_req_valid     = 1'bx;
        l2_req_type      = memory_operation_e'('x);
        l2_req_address   = 'x;
        l2_req_wdata     = 'x;
        ic_req_fulfilled = 1'bx;
        dc_req_fulfilled = 1'bx;
        ic_rdata         = 'x;
        dc_rdata         = 'x;
      end
    endcase
  end

`ifdef L2_ARB_PERF_COUNTERS_EN
  logic [31:0] ic_grant_cnt_q;
  logic [31:0] dc_grant_cnt_q;

  // Grant counters: one increment per idle-to-grant transition, natural wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ic_grant_cnt_q <= '0;
      dc_grant_cnt_q <= '0;
    end else begin
      if (take_ic) ic_grant_cnt_q <= ic_grant_cnt_q + 32'd1;
      if (take_dc) dc_grant_cnt_q <= dc_grant_cnt_q + 32'd1;
    end
  end

  assign ic_grant_count = ic_grant_cnt_q;
  assign dc_grant_count = dc_grant_cnt_q;
`endif

endmodule

// File: tb/tb_l2_request_arbiter.sv
// tb_l2_request_arbiter: directed bench for l2_request_arbiter. Each step states
// which client should own the L2 channel; the expected channel outputs for that
// step are queued when inputs are driven and compared at the falling edge.
// Build with L2_ARB_PERF_COUNTERS_EN to also cover the grant counters.

module tb_l2_request_arbiter;
  import l2_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              ic_v;
  memory_operation_e ic_t;
  logic [AW-1:0]     ic_a;
  logic              ic_f;
  logic [DW-1:0]     ic_rd;
  logic              dc_v;
  memory_operation_e dc_t;
  logic [AW-1:0]     dc_a;
  logic [DW-1:0]     dc_wd;
  logic              dc_f;
  logic [DW-1:0]     dc_rd;
  logic              l2_v;
  memory_operation_e l2_t;
  logic [AW-1:0]     l2_a;
  logic [DW-1:0]     l2_wd;
  logic              l2_f;
  logic [DW-1:0]     l2_rd;
`ifdef L2_ARB_PERF_COUNTERS_EN
  logic [31:0]       ic_cnt;
  logic [31:0]       dc_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string             tag;
    logic              v;
    memory_operation_e t;
    logic [AW-1:0]     a;
    logic [DW-1:0]     wd;
    logic              icf;
    logic              dcf;
    logic [DW-1:0]     rd;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  l2_request_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ic_req_valid     (ic_v),
    .ic_req_type      (ic_t),
    .ic_req_address   (ic_a),
    .ic_req_fulfilled (ic_f),
    .ic_rdata         (ic_rd),
    .dc_req_valid     (dc_v),
    .dc_req_type      (dc_t),
    .dc_req_address   (dc_a),
    .dc_req_wdata     (dc_wd),
    .dc_req_fulfilled (dc_f),
    .dc_rdata         (dc_rd),
    .l2_req_valid     (l2_v),
    .l2_req_type      (l2_t),
    .l2_req_address   (l2_a),
    .l2_req_wdata     (l2_wd),
    .l2_req_fulfilled (l2_f),
    .l2_rdata         (l2_rd)
`ifdef L2_ARB_PERF_COUNTERS_EN
    ,
    .ic_grant_count   (ic_cnt),
    .dc_grant_count   (dc_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One cycle: g = expected owner (0 idle, 1 icache, 2 dcache) for the current inputs
  task automatic cyc(input int g, input string tag);
    exp_t e;
    e.tag = tag;
    e.rd  = l2_rd;
    case (g)
      1: begin
        e.v = ic_v; e.t = ic_t; e.a = ic_a; e.wd = '0;
        e.icf = l2_f; e.dcf = 1'b0;
      end
      2: begin
        e.v = dc_v; e.t = dc_t; e.a = dc_a; e.wd = dc_wd;
        e.icf = 1'b0; e.dcf = l2_f;
      end
      default: begin
        e.v = 1'b0; e.t = LOAD; e.a = '0; e.wd = '0;
        e.icf = 1'b0; e.dcf = 1'b0;
      end
    endcase
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    chk({e.tag, ".valid"}, 64'(l2_v), 64'(e.v));
    chk({e.tag, ".type"}, 64'(l2_t), 64'(e.t));
    chk({e.tag, ".addr"}, 64'(l2_a), 64'(e.a));
    chk({e.tag, ".wdata"}, 64'(l2_wd), 64'(e.wd));
    chk({e.tag, ".ic_ful"}, 64'(ic_f), 64'(e.icf));
    chk({e.tag, ".dc_ful"}, 64'(dc_f), 64'(e.dcf));
    chk({e.tag, ".ic_rd"}, 64'(ic_rd), 64'(e.rd));
    chk({e.tag, ".dc_rd"}, 64'(dc_rd), 64'(e.rd));
    @(posedge clk);
    #1;
    l2_rd = $urandom;
  endtask

  // A lone single-beat grant for one client, starting and ending idle
  task automatic grant_once(input int g);
    if (g == 1) ic_v = 1'b1; else dc_v = 1'b1;
    cyc(0, "one_req");
    l2_f = 1'b1;
    cyc(g, "one_beat");
    l2_f = 1'b0;
    if (g == 1) ic_v = 1'b0; else dc_v = 1'b0;
    cyc(g, "one_drop");
    cyc(0, "one_idle");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int own;
    reset_n = 1'b0;
    ic_v = 1'b1; ic_t = LOAD; ic_a = 32'h0000_0100;
    dc_v = 1'b1; dc_t = LOAD; dc_a = 32'h0000_0200; dc_wd = 32'h1234_5678;
    l2_f = 1'b1; l2_rd = 32'hA5A5_0001;
    @(posedge clk);
    #1;
    // Reset state: no pass-through even with both clients valid and L2 fulfilling
    cyc(0, "reset");

    // Reset tie: icache wins, four beats, then dcache two cycles after release
    reset_n = 1'b1;
    l2_f = 1'b0;
    cyc(0, "tie_idle");
    l2_f = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1, "tie_ic");
      ic_a = ic_a + 32'd4;
    end
    ic_v = 1'b0;
    l2_f = 1'b0;
    cyc(1, "tie_ic_rel");
    cyc(0, "tie_gap");
    cyc(2, "tie_dc");
    dc_v = 1'b0;
    cyc(2, "tie_dc_rel");
    cyc(0, "tie_end");

    // Exclusive grant: 16-beat icache burst, dcache arrives mid-burst
    ic_v = 1'b1; ic_a = 32'h0000_1000;
    cyc(0, "burst_req");
    for (int i = 0; i < 32; i++) begin
      l2_f = (i % 2 == 0);
      if (i == 8) begin
        dc_v = 1'b1;
        dc_a = 32'hBAD0_0000;
      end
      cyc(1, "burst");
      if (l2_f) ic_a = ic_a + 32'd4;
    end
    ic_v = 1'b0;
    l2_f = 1'b0;
    cyc(1, "burst_rel");
    cyc(0, "burst_gap");
    cyc(2, "burst_dc");
    dc_v = 1'b0;
    cyc(2, "burst_dc_rel");
    cyc(0, "burst_end");

    // Alternation: both clients re-request immediately after each release
    ic_v = 1'b1;
    dc_v = 1'b1;
    cyc(0, "alt_req");
    own = 1;
    for (int i = 0; i < 4; i++) begin
      l2_f = 1'b1;
      cyc(own, "alt_beat");
      l2_f = 1'b0;
      if (own == 1) ic_v = 1'b0; else dc_v = 1'b0;
      cyc(own, "alt_drop");
      ic_v = 1'b1;
      dc_v = 1'b1;
      cyc(0, "alt_idle");
      own = 3 - own;
    end
    ic_v = 1'b0;
    dc_v = 1'b0;
    cyc(1, "alt_end_ic");
    cyc(0, "alt_end");

    // Dcache store pass-through; fulfilled while idle is ignored
    dc_v = 1'b1; dc_t = STORE; dc_a = 32'h8000_0040; dc_wd = 32'hDEAD_BEEF;
    l2_f = 1'b1;
    cyc(0, "idle_ful");
    cyc(2, "st_pass");
    l2_f = 1'b0;
    cyc(2, "st_hold");

    // Reset mid-grant: channel drops immediately, lone icache granted after release
    reset_n = 1'b0;
    cyc(0, "rst_mid");
    dc_v = 1'b0; dc_t = LOAD;
    ic_v = 1'b1; ic_a = 32'h0000_3000;
    reset_n = 1'b1;
    cyc(0, "post_rst_idle");
    l2_f = 1'b1;
    cyc(1, "post_rst_ic");
    l2_f = 1'b0;
    ic_v = 1'b0;
    cyc(1, "post_rst_rel");
    cyc(0, "post_rst_end");

`ifdef L2_ARB_PERF_COUNTERS_EN
    // Counters restarted at the mid-grant reset; one icache grant since then
    grant_once(1);
    grant_once(2);
    grant_once(1);
    grant_once(2);
    chk("cnt_ic", 64'(ic_cnt), 64'd3);
    chk("cnt_dc", 64'(dc_cnt), 64'd2);
    force dut.ic_grant_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.ic_grant_cnt_q;
    chk("cnt_preload", 64'(ic_cnt), 64'hFFFF_FFFF);
    grant_once(1);
    chk("cnt_wrap", 64'(ic_cnt), 64'd0);
    chk("cnt_dc_hold", 64'(dc_cnt), 64'd2);
`else
    grant_once(2);
    grant_once(1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/l2_request_arbiter.md
# l2_request_arbiter

Arbitrates the instruction cache's and data cache's L2 request channels onto the single L2 request channel, passing one client's multi-beat transaction through at a time. Sits directly downstream of both L1 controllers and upstream of the L2.
- A client keeps its request valid for a whole operation, e.g. an icache line allocate with one `l2_req_fulfilled` per beat.
- The arbiter holds its grant until that client drops valid.
- Round-robin arbitration prevents a streaming client from starving the other.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, L2 request address width
- `DATA_WIDTH`, 32, beat data width

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `ic_req_valid`  in  1  icache request valid, held for whole operation
- `ic_req_type`  in  `memory_operation_e`  icache operation (LOAD only in practice)
- `ic_req_address`  in  ADDR_WIDTH  icache beat address
- `ic_req_fulfilled`  out  1  icache beat completed
- `ic_rdata`  out  DATA_WIDTH  L2 read data to icache
- `dc_req_valid`  in  1  dcache request valid, held for whole operation
- `dc_req_type`  in  `memory_operation_e`  dcache operation (LOAD/STORE)
- `dc_req_address`  in  ADDR_WIDTH  dcache beat address
- `dc_req_wdata`  in  DATA_WIDTH  dcache write data
- `dc_req_fulfilled`  out  1  dcache beat completed
- `dc_rdata`  out  DATA_WIDTH  L2 read data to dcache
- `l2_req_valid`  out  1  request to L2
- `l2_req_type`  out  `memory_operation_e`  operation to L2
- `l2_req_address`  out  ADDR_WIDTH  address to L2
- `l2_req_wdata`  out  DATA_WIDTH  write data to L2
- `l2_req_fulfilled`  in  1  L2 beat completed
- `l2_rdata`  in  DATA_WIDTH  L2 read data

## Operation
States:
- `ST_IDLE`: no grant.
- `ST_GRANT_IC` / `ST_GRANT_DC`: the named client owns the L2 channel.
- Any other encoding drives all outputs and `next_state` to X.

`last_grant` register: 1 bit, 0 = IC, 1 = DC; resets to DC, so IC wins the first tie.

Transitions from `ST_IDLE`:
- Only one valid → grant that client.
- Both valid → grant the client that is not `last_grant`.
- `last_grant` updates when a grant is taken.

Transitions from a grant state:
- Granted client valid high → stay.
- Granted client valid low → `ST_IDLE`. The other client's request waits and is granted from `ST_IDLE` on the following edge.

Datapath:
- In a grant state, the `l2_req_*` outputs are the combinational pass-through of the granted client's `valid`, `type`, `address` and `wdata`.
- IC granted: `l2_req_wdata` = '0.
- `ST_IDLE`: `l2_req_valid` = 0, `l2_req_type` = LOAD, address and wdata = '0.
- `l2_req_fulfilled` routes only to the granted client's `*_req_fulfilled`; the ungranted client's is 0.
- `l2_rdata` fans out to both `ic_rdata` and `dc_rdata`; only the granted client may consume it.

## Timing
- Reset (async assert, sync release): state = `ST_IDLE`, `last_grant` = DC.
  - All outputs reset to: `l2_req_valid` = 0, `ic/dc_req_fulfilled` = 0, `l2_req_type` = LOAD, data/address = 0.
  - Reset mid-transaction abandons the beat; clients restart from their own reset.
- Grant latency: client valid rises in cycle N in `ST_IDLE` → `l2_req_valid` high in cycle N+1.
- Fulfilled path: combinational, zero-cycle from `l2_req_fulfilled` to client.
- Release: granted valid low in cycle M → `l2_req_valid` low in cycle M (pass-through), `ST_IDLE` at M+1, next grant visible at M+2.
- `l2_req_fulfilled` while idle is ignored (both client fulfilleds stay 0).
- The other client asserting valid during a grant never preempts the grant.

## Configuration
`L2_ARB_PERF_COUNTERS_EN`:
- Defined: adds outputs `ic_grant_count` and `dc_grant_count` (32 bits each, reset 0).
  - Each increments once per `ST_IDLE` → grant transition for its client.
  - Each wraps 0xFFFF_FFFF → 0.
- Undefined: these ports and their registers do not exist; arbitration behaviour is identical.

## Test plan
- **Reset tie:** both valid in cycle 1 after reset → IC granted at cycle 2. IC releases after 4 fulfilled beats → DC granted 2 cycles later.
- **Exclusive grant during IC burst:**
  - IC holds valid for 16 beats with `l2_req_fulfilled` every other cycle.
  - DC asserts mid-burst → `dc_req_fulfilled` stays 0 and `l2_req_address` tracks IC throughout.
- **Alternation:** both clients continuously re-request → grants alternate IC, DC, IC, DC; `last_grant` toggles each grant.
- **DC store pass-through:** DC STORE, address 0x8000_0040, wdata 0xDEAD_BEEF → `l2_req_type` = STORE with same address and wdata at cycle N+1; fulfilled returns only to DC.
- **Reset mid-burst:** `reset_n` low during `ST_GRANT_DC` → `l2_req_valid` 0 immediately; after release, a lone IC request is granted on the next edge.
- **Counter wrap (with `L2_ARB_PERF_COUNTERS_EN`):** 3 IC grants and 2 DC grants → counts 3 and 2. A forced preload of 0xFFFF_FFFF wraps to 0 on the next grant.
